frame_config_writer: RTL and testbench



---
 rtl/frame_cfg_pkg.sv | 31 +++
 rtl/frame_strobe_decoder.sv | 34 +++
 rtl/frame_config_writer.sv | 166 ++++++++++++++++
 tb/tb_frame_config_writer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the configuration frame writer.
// Holds the parser state enum, the default stream sync word and the bit
// positions of the fields inside a frame header word.
package frame_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR    = 2'd1,
        DATA   = 2'd2,
        STROBE = 2'd3
    } state_e;

    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

    // Header word layout: bit 31 marks end of configuration, otherwise
    // [15:8] is the column and [4:0] the frame within that column.
    localparam int EOC_BIT   = 31;
    localparam int COL_MSB   = 15;
    localparam int COL_LSB   = 8;
    localparam int FRAME_MSB = 4;
    localparam int FRAME_LSB = 0;

    localparam int COL_W   = COL_MSB - COL_LSB + 1;
    localparam int FRAME_W = FRAME_MSB - FRAME_LSB + 1;

    // Row counter width: clog2 of the row count, never narrower than 1 bit.
    function automatic int row_cnt_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Combinational column/frame -> FrameStrobe decoder.
// Ports:
//   col    in   COL_W    column field from the frame header
//   frame  in   FRAME_W  frame field from the frame header
//   onehot out  NumberOfCols*MaxFramesPerCol  bit col*MaxFramesPerCol+frame, or zero
//   valid  out  1        address lies inside the fabric
// The index is formed at 32 bits before the range check so that an
// out-of-range column or frame can never alias onto a legal strobe bit.
module frame_strobe_decoder
    import frame_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int NumberOfCols    = 4
) (
    input  logic [COL_W-1:0]                        col,
    input  logic [FRAME_W-1:0]                      frame,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] onehot,
    output logic                                    valid
);

    localparam int NUM_STROBES = NumberOfCols * MaxFramesPerCol;

    logic [31:0] index;

    always_comb begin
        valid  = (32'(col) < 32'(NumberOfCols)) && (32'(frame) < 32'(MaxFramesPerCol));
        index  = 32'(col) * 32'(MaxFramesPerCol) + 32'(frame);
        onehot = '0;
        for (int i = 0; i < NUM_STROBES; i++) begin
            onehot[i] = valid && (index == 32'(i));
        end
    end

endmodule

// File: rtl/frame_config_writer.sv
// Configuration frame writer: parses a 32-bit bitstream word stream
// (sync word, frame headers, row data words) and drives the fabric's
// FrameData bus plus a single-cycle FrameStrobe for the addressed frame.
// Ports:
//   CLK          in   1     clock
//   resetn       in   1     asynchronous active-low reset
//   s_data       in   32    bitstream word
//   s_valid      in   1     word valid
//   s_ready      out  1     word consumed when s_valid && s_ready
//   FrameData    out  NumberOfRows*FrameBitsPerRow, row r at [r*32 +: 32]
//   FrameStrobe  out  NumberOfCols*MaxFramesPerCol, column c frame f at c*MaxFramesPerCol+f
//   busy         out  1     parser is not idle
//   config_done  out  1     one-cycle pulse after the end-of-config header
//   addr_error   out  1     sticky: a frame addressed outside the fabric
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | discard words until the sync word arrives
// HDR    | next word is a frame header or the end-of-config marker
// DATA   | collecting row data words for the latched column/frame
// STROBE | one cycle with FrameStrobe high; input is held off
module frame_config_writer
    import frame_cfg_pkg::*;
#(
    parameter int          FrameBitsPerRow = 32,
    parameter int          MaxFramesPerCol = 20,
    parameter int          NumberOfRows    = 4,
    parameter int          NumberOfCols    = 4,
    parameter logic [31:0] SyncWord        = SYNC_WORD_DEFAULT
) (
    input  logic                                       CLK,
    input  logic                                       resetn,
    input  logic [FrameBitsPerRow-1:0]                 s_data,
    input  logic                                       s_valid,
    output logic                                       s_ready,
    output logic [NumberOfRows*FrameBitsPerRow-1:0]    FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0]    FrameStrobe,
    output logic                                       busy,
    output logic                                       config_done,
    output logic                                       addr_error
);

    localparam int ROW_W       = row_cnt_width(NumberOfRows);
    localparam int NUM_STROBES = NumberOfCols * MaxFramesPerCol;
    localparam int DATA_W      = NumberOfRows * FrameBitsPerRow;

    state_e                   state_q, state_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [FRAME_W-1:0]       frame_q, frame_d;
    logic [DATA_W-1:0]        frame_data_q, frame_data_d;
    logic [NUM_STROBES-1:0]   strobe_q, strobe_d;
    logic                     s_ready_q, s_ready_d;
    logic                     busy_q, busy_d;
    logic                     config_done_q, config_done_d;
    logic                     addr_error_q, addr_error_d;

    logic [NUM_STROBES-1:0]   dec_onehot;
    logic                     dec_valid;
    logic                     accept;

    frame_strobe_decoder #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .NumberOfCols    (NumberOfCols)
    ) u_decoder (
        .col    (col_q),
        .frame  (frame_q),
        .onehot (dec_onehot),
        .valid  (dec_valid)
    );

    assign accept = s_valid && s_ready_q;

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        frame_d       = frame_q;
        frame_data_d  = frame_data_q;
        strobe_d      = '0;
        config_done_d = 1'b0;
        addr_error_d  = addr_error_q;

        unique case (state_q)
            IDLE: begin
                if (accept && (s_data == SyncWord)) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                if (accept) begin
                    if (s_data[EOC_BIT]) begin
                        config_done_d = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        col_d   = s_data[COL_MSB:COL_LSB];
                        frame_d = s_data[FRAME_MSB:FRAME_LSB];
                        row_d   = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    frame_data_d[int'(row_q)*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
                    if (row_q == ROW_W'(NumberOfRows - 1)) begin
                        // The last row and the strobe launch from the same
                        // edge; the row is on FrameData for the whole strobe.
                        strobe_d = dec_onehot;
                        if (!dec_valid) begin
                            addr_error_d = 1'b1;
                        end
                        row_d   = '0;
                        state_d = STROBE;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            STROBE: begin
                state_d = HDR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered handshake: low exactly while the parser sits in STROBE.
        s_ready_d = (state_d != STROBE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            frame_q       <= '0;
            frame_data_q  <= '0;
            strobe_q      <= '0;
            s_ready_q     <= 1'b0;
            busy_q        <= 1'b0;
            config_done_q <= 1'b0;
            addr_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            frame_q       <= frame_d;
            frame_data_q  <= frame_data_d;
            strobe_q      <= strobe_d;
            s_ready_q     <= s_ready_d;
            busy_q        <= busy_d;
            config_done_q <= config_done_d;
            addr_error_q  <= addr_error_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign FrameData   = frame_data_q;
    assign FrameStrobe = strobe_q;
    assign busy        = busy_q;
    assign config_done = config_done_q;
    assign addr_error  = addr_error_q;

endmodule

// File: tb/tb_frame_config_writer.sv
// Self-checking bench for frame_config_writer.
module tb_frame_config_writer;
    import frame_cfg_pkg::*;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int FPC  = 20;
    localparam int FBR  = 32;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
    localparam logic [31:0] EOC  = 32'h8000_0000;

    logic                   clk = 1'b0;
    logic                   resetn = 1'b0;
    logic [FBR-1:0]         s_data = '0;
    logic                   s_valid = 1'b0;
    logic                   s_ready;
    logic [ROWS*FBR-1:0]    frame_data;
    logic [COLS*FPC-1:0]    frame_strobe;
    logic                   busy;
    logic                   config_done;
    logic                   addr_error;

    frame_config_writer dut (
        .CLK         (clk),
        .resetn      (resetn),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (frame_data),
        .FrameStrobe (frame_strobe),
        .busy        (busy),
        .config_done (config_done),
        .addr_error  (addr_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;

    // Reference state: what FrameData and addr_error must hold.
    logic [ROWS*FBR-1:0] m_fd = '0;
    logic                m_err = 1'b0;

    typedef struct {
        int              c;
        int              idx;
        logic [127:0]    fd;
    } strobe_ev_t;

    strobe_ev_t strobes[$];
    int         done_cyc[$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_strobe != '0) begin
            int idx;
            idx = -1;
            chk("strobe_onehot", 128'($countones(frame_strobe)), 128'd1);
            chk("ready_low_during_strobe", 128'(s_ready), 128'd0);
            for (int i = 0; i < COLS*FPC; i++) if (frame_strobe[i]) idx = i;
            strobes.push_back('{cyc, idx, 128'(frame_data)});
        end
        if (config_done) done_cyc.push_back(cyc);
    end

    function automatic int ref_idx(input int col, input int frm);
        return (col < COLS && frm < FPC) ? col * FPC + frm : -1;
    endfunction

    function automatic logic [31:0] mk_hdr(input logic [7:0] col, input logic [4:0] frm);
        logic [31:0] h;
        h       = $urandom;
        h[31]   = 1'b0;
        h[15:8] = col;
        h[4:0]  = frm;
        return h;
    endfunction

    // Called and returns just after a rising edge.
    task automatic send(input logic [31:0] w, input int max_gap);
        int  g;
        bit  ok;
        g  = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        ok = 1'b0;
        repeat (g) begin
            s_data = $urandom;
            @(posedge clk); #1;
        end
        s_data  = w;
        s_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (s_ready) begin
                last_acc = cyc;
                ok = 1'b1;
            end
            @(posedge clk); #1;
            if (ok) break;
        end
        s_valid = 1'b0;
        if (!ok) chk("accept_timeout", 128'd0, 128'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic run_frame(input string name, input logic [7:0] col, input logic [4:0] frm,
                             input logic [127:0] data, input int exp_idx, input int max_gap);
        int acc_end;
        strobes.delete();
        send(mk_hdr(col, frm), max_gap);
        for (int r = 0; r < ROWS; r++) send(data[r*FBR +: FBR], max_gap);
        acc_end = last_acc;
        idle_cycles(3);
        m_fd = data;
        if (exp_idx < 0) m_err = 1'b1;
        chk({name, " strobe_count"}, 128'(strobes.size()), (exp_idx >= 0) ? 128'd1 : 128'd0);
        if (exp_idx >= 0 && strobes.size() > 0) begin
            chk({name, " strobe_idx"}, 128'(strobes[0].idx), 128'(exp_idx));
            chk({name, " strobe_latency"}, 128'(strobes[0].c), 128'(acc_end + 1));
            chk({name, " data_at_strobe"}, strobes[0].fd, data);
        end
        chk({name, " frame_data"}, frame_data, m_fd);
        chk({name, " addr_error"}, 128'(addr_error), 128'(m_err));
    endtask

    task automatic check_all_zero(input string name);
        chk({name, " FrameData"}, frame_data, '0);
        chk({name, " FrameStrobe"}, 128'(frame_strobe), '0);
        chk({name, " s_ready"}, 128'(s_ready), '0);
        chk({name, " busy"}, 128'(busy), '0);
        chk({name, " config_done"}, 128'(config_done), '0);
        chk({name, " addr_error"}, 128'(addr_error), '0);
    endtask

    typedef struct {
        logic [7:0]   col;
        logic [4:0]   frm;
        logic [127:0] data;
        int           exp_idx;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        int acc;
        int acc_a, acc_b;

        vecs[0] = '{8'd2, 5'd3,  {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 43};
        vecs[1] = '{8'd0, 5'd0,  {32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3}, 0};
        vecs[2] = '{8'd5, 5'd3,  {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210}, -1};
        vecs[3] = '{8'd1, 5'd19, {32'hFAB0FAB1, 32'h0BADF00D, 32'hFAB0FAB1, 32'h12345678}, 39};
        vecs[4] = '{8'd3, 5'd19, {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000001}, 79};
        vecs[5] = '{8'd4, 5'd0,  {32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888}, -1};
        vecs[6] = '{8'd0, 5'd20, {32'h9999AAAA, 32'hBBBBCCCC, 32'hDDDDEEEE, 32'hFFFF0000}, -1};
        vecs[7] = '{8'd3, 5'd0,  {32'hCAFEBABE, 32'hDEADBEEF, 32'h8BADF00D, 32'hFEEDFACE}, 60};

        // Reset state and the held-off cycle after release.
        #2;
        check_all_zero("reset");
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 128'(s_ready), 128'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_second_cycle", 128'(s_ready), 128'd1);
        chk("busy_idle", 128'(busy), 128'd0);
        @(posedge clk); #1;

        // Garbage before sync is discarded.
        send(32'hDEADBEEF, 0);
        send(32'h00000000, 0);
        idle_cycles(1);
        chk("garbage_busy", 128'(busy), 128'd0);
        send(SYNC, 0);
        idle_cycles(1);
        chk("sync_busy", 128'(busy), 128'd1);

        for (int i = 0; i < 8; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].col, vecs[i].frm, vecs[i].data, vecs[i].exp_idx, 0);

        done_cyc.delete();
        send(EOC, 0);
        acc = last_acc;
        idle_cycles(2);
        chk("eoc_pulse_count", 128'(done_cyc.size()), 128'd1);
        if (done_cyc.size() > 0) chk("eoc_pulse_cycle", 128'(done_cyc[0]), 128'(acc + 1));
        chk("eoc_busy", 128'(busy), 128'd0);

        // Randomised frames with gaps in s_valid.
        send(SYNC, 2);
        for (int i = 0; i < 30; i++) begin
            logic [7:0]   c;
            logic [4:0]   f;
            logic [127:0] d;
            c = 8'($urandom_range(0, 6));
            f = 5'($urandom_range(0, 25));
            d = {$urandom, $urandom, $urandom, $urandom};
            run_frame($sformatf("rnd%0d", i), c, f, d, ref_idx(int'(c), int'(f)), 3);
        end

        // Partial frame keeps unwritten rows, then reset mid-DATA.
        strobes.delete();
        send(mk_hdr(8'd1, 5'd2), 0);
        send(32'h0000AAAA, 1);
        send(32'h0000BBBB, 1);
        idle_cycles(1);
        chk("partial_rows", frame_data, {m_fd[127:64], 32'h0000BBBB, 32'h0000AAAA});
        #3 resetn = 1'b0;
        #1 check_all_zero("mid_reset");
        m_fd  = '0;
        m_err = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        idle_cycles(2);
        // Without a new sync word the frame is ignored.
        send(mk_hdr(8'd1, 5'd2), 0);
        for (int r = 0; r < ROWS; r++) send(32'h13572468 + 32'(r), 0);
        idle_cycles(3);
        chk("no_sync strobe_count", 128'(strobes.size()), 128'd0);
        chk("no_sync frame_data", frame_data, m_fd);
        chk("no_sync busy", 128'(busy), 128'd0);

        // Two back-to-back frames, no gaps.
        send(SYNC, 0);
        strobes.delete();
        send(mk_hdr(8'd3, 5'd0), 0);
        for (int r = 0; r < ROWS; r++) send(32'h30300000 + 32'(r), 0);
        acc_a = last_acc;
        send(mk_hdr(8'd3, 5'd1), 0);
        acc_b = last_acc;
        for (int r = 0; r < ROWS; r++) send(32'h31310000 + 32'(r), 0);
        acc = last_acc;
        idle_cycles(3);
        chk("b2b header_held_off", 128'(acc_b), 128'(acc_a + 2));
        chk("b2b strobe_count", 128'(strobes.size()), 128'd2);
        if (strobes.size() == 2) begin
            chk("b2b idx0", 128'(strobes[0].idx), 128'd60);
            chk("b2b idx1", 128'(strobes[1].idx), 128'd61);
            chk("b2b cyc0", 128'(strobes[0].c), 128'(acc_a + 1));
            chk("b2b cyc1", 128'(strobes[1].c), 128'(acc + 1));
            chk("b2b fd0", strobes[0].fd, {32'h30300003, 32'h30300002, 32'h30300001, 32'h30300000});
        end
        chk("b2b final_fd", frame_data, {32'h31310003, 32'h31310002, 32'h31310001, 32'h31310000});
        chk("b2b addr_error", 128'(addr_error), 128'd0);

        done_cyc.delete();
        send(EOC, 0);
        idle_cycles(2);
        chk("final_eoc_count", 128'(done_cyc.size()), 128'd1);
        chk("final_busy", 128'(busy), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
